keypad_scanner: RTL

Scans the calculator's 4-row x 5-column key matrix, debounces it, and turns each accepted key press into a single-cycle command pulse. It sits directly upstream of the operand register block and drives that block's `newhex`/`hexcode`, `newop`, `eq` and `BS` inputs. Only one key is accepted at a time. Multi-key presses are rejected.

---
 rtl/keypad_scanner.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x5 key-matrix scanner: row strobing, frame-level debounce and one-key-at-a-time
// acceptance, producing single-cycle command pulses for the operand register block.
module keypad_scanner #(
  parameter int SCAN_DIV = 5000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] cols,
  output logic [3:0] rows,
  output logic       newhex,
  output logic [3:0] hexcode,
  output logic       newop,
  output logic       op,
  output logic       eq,
  output logic       BS
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;

  logic [4:0]    cols_meta, cols_sync;
  logic [DW-1:0] div;
  logic [1:0]    row_idx;
  logic          tc;

  // Closure count so far in the frame saturates at 2 (= MULTI); key is valid when count is 1.
  logic [1:0]    acc_cnt, frame_cnt;
  logic [4:0]    acc_key, frame_key;
  logic          frame_vld;

  logic [4:0]    closed;
  logic [2:0]    row_hits, sum;
  logic [2:0]    row_col;
  logic [4:0]    row_key, tot_key;
  logic [1:0]    tot_cnt;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, rcnt, rcnt_n;
  logic [4:0]    cand, cand_n;
  logic          accept;

  assign tc = (div == DW'(SCAN_DIV - 1));

  always_comb begin
    rows = 4'b1111;
    rows[row_idx] = 1'b0;
  end

  // NOTE: every signal assigned in a combinational block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    closed   = ~cols_sync;
    row_hits = 3'(closed[0]) + 3'(closed[1]) + 3'(closed[2]) + 3'(closed[3]) + 3'(closed[4]);
    row_col  = 3'd0;
    for (int c = 4; c >= 0; c--) begin
      if (closed[c]) row_col = 3'(c);
    end
    row_key = (row_col == 3'd4) ? {3'b100, row_idx} : {1'b0, row_idx, row_col[1:0]};
    sum     = 3'(acc_cnt) + row_hits;
    tot_cnt = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    tot_key = (acc_cnt == 2'd0) ? row_key : acc_key;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cols_meta <= '0;
      cols_sync <= '0;
      div       <= '0;
      row_idx   <= 2'd0;
      acc_cnt   <= 2'd0;
      acc_key   <= 5'd0;
      frame_vld <= 1'b0;
      frame_cnt <= 2'd0;
      frame_key <= 5'd0;
    end else begin
      cols_meta <= cols;
      cols_sync <= cols_meta;
      frame_vld <= 1'b0;
      if (tc) begin
        div     <= '0;
        row_idx <= row_idx + 2'd1;
        if (row_idx == 2'd3) begin
          frame_vld <= 1'b1;
          frame_cnt <= tot_cnt;
          frame_key <= tot_key;
          acc_cnt   <= 2'd0;
          acc_key   <= 5'd0;
        end else begin
          acc_cnt <= tot_cnt;
          acc_key <= tot_key;
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  // The FSM advances only on the cycle a completed frame result is presented.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rcnt_n  = rcnt;
    cand_n  = cand;
    accept  = 1'b0;
    if (frame_vld) begin
      case (state)
        IDLE: begin
          if (frame_cnt == 2'd1) begin
            cand_n = frame_key;
            cnt_n  = CW'(1);
            if (DEBOUNCE == 1) begin
              accept  = 1'b1;
              state_n = HELD;
              rcnt_n  = '0;
            end else begin
              state_n = PRESS;
            end
          end else if (frame_cnt == 2'd2) begin
            state_n = HELD;
            rcnt_n  = '0;
          end
        end
        PRESS: begin
          if (frame_cnt == 2'd1 && frame_key == cand) begin
            cnt_n = cnt + CW'(1);
            if (cnt + CW'(1) == CW'(DEBOUNCE)) begin
              accept  = 1'b1;
              state_n = HELD;
              rcnt_n  = '0;
            end
          end else if (frame_cnt == 2'd2) begin
            state_n = HELD;
            rcnt_n  = '0;
          end else begin
            state_n = IDLE;
          end
        end
        HELD: begin
          if (frame_cnt != 2'd0) begin
            rcnt_n = '0;
          end else if (rcnt + CW'(1) == CW'(DEBOUNCE)) begin
            state_n = IDLE;
            rcnt_n  = '0;
          end else begin
            rcnt_n = rcnt + CW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rcnt    <= '0;
      cand    <= 5'd0;
      newhex  <= 1'b0;
      hexcode <= 4'd0;
      newop   <= 1'b0;
      op      <= 1'b0;
      eq      <= 1'b0;
      BS      <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rcnt   <= rcnt_n;
      cand   <= cand_n;
      newhex <= 1'b0;
      newop  <= 1'b0;
      eq     <= 1'b0;
      BS     <= 1'b0;
      if (accept) begin
        if (!cand_n[4]) begin
          newhex  <= 1'b1;
          hexcode <= cand_n[3:0];
        end else begin
          case (cand_n[1:0])
            2'd0: begin newop <= 1'b1; op <= 1'b0; end
            2'd1: begin newop <= 1'b1; op <= 1'b1; end
            2'd2: eq <= 1'b1;
            default: BS <= 1'b1;
          endcase
        end
      end
    end
  end

endmodule
